suma_resta_seg: RTL and testbench
=================================

# suma_resta_seg

Pipelined, parametrised add/subtract unit for the CPU execute stage, successor to the single-cycle flag-producing adder. It performs ADD/ADC/SUB/SBC/RSB and flag-only compares on N-bit operands, produces full NZCV flags (including signed overflow and borrow-aware carry), and keeps an architectural flag register that feeds carry-in to ADC/SBC. Two register stages with valid/ready handshakes on input and output sustain one operation per cycle under backpressure.

## Interface
- N, 32, operand/result width (N >= 2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts operation this cycle
- op  in  3  000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 CMP, 101 CMN, 110 RSB, 111 PASS
- a, b  in  N  operands
- set_flags  in  1  update flag register with this op's flags
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- c  out  N  result
- banderas  out  4  flags of this result: [3] N, [2] Z, [1] C, [0] V
- flags_reg  out  4  architectural flag register, same bit order

## Operation
- Stage S1 (operand register): captures op, a, b, set_flags on input handshake (in_valid && in_ready).
- Stage S2 (result register): computed on S1->S2 transfer; holds c, banderas; drives outputs.
- Adder operands (x, y, cin): ADD/CMN: a, b, 0; ADC: a, b, flags_reg[1]; SUB/CMP: a, ~b, 1; SBC: a, ~b, flags_reg[1]; RSB: b, ~a, 1.
- Sum: {carry, c} = x + y + cin in N+1 bits; c = low N bits. CMP/CMN still output c.
- N = c[N-1]; Z = (c == 0); C = carry (subtract: 1 = no borrow); V = (x[N-1] == y[N-1]) && (c[N-1] != x[N-1]).
- PASS: c = a, banderas = 0000, flag register never updated.
- flags_reg loads banderas on the same edge the op enters S2 when (set_flags || op is CMP/CMN) and op != PASS. Because ops enter S2 in order, an ADC/SBC always sees carry from every earlier op; no forwarding or stall needed.
- Advance rules: S2 empties when out_valid && out_ready; S1->S2 when S1 valid and (S2 empty or S2 emptying); in_ready = !s1_valid || S1 advancing this cycle.
- Order preserved; no op dropped or duplicated.

## Timing
- Latency: op accepted at edge E0 enters S2 at E1 (if unstalled); out_valid high after E1.
- Throughput: 1 op/cycle with out_ready held high.
- Backpressure: while out_valid && !out_ready, c, banderas, out_valid hold stable; S1 may still fill once, then in_ready = 0.
- Simultaneous output pop and input push with both stages full: allowed, in_ready = 1 that cycle, full throughput.
- in_ready is combinational from out_ready; out_valid, c, banderas, flags_reg are registered.
- Reset (async, any time, including mid-operation): in-flight ops discarded; out_valid = 0, c = 0, banderas = 0000, flags_reg = 0000, both stages empty; in_ready = 1 once rst_n deasserts. First accept possible on first edge after release.
- Width rules: no carry beyond bit N; result wraps modulo 2^N.

## Test plan
- N=8, ADD 0x7F+0x01, set_flags=1 -> c=0x80, banderas=1001, flags_reg=1001 one cycle after accept.
- N=8, SUB 0x05-0x05 then CMP 0x00,0x01 -> c=0x00 banderas=0110; c=0xFF banderas=1000, flags_reg=1000 though set_flags=0.
- N=8, back-to-back ADD 0xFF+0x01 (set_flags) then ADC 0x00+0x00 -> c=0x00 banderas=0110, then c=0x01 banderas=0000; repeat with SUB 0x00-0x01 then SBC 0x00-0x00 -> second c=0xFF banderas=1000.
- out_ready=0, issue 3 ops with in_valid held -> two accepted, in_ready=0 on third, outputs stable; raise out_ready -> three results in order on consecutive cycles.
- Random ops, random out_ready, N=16 and N=32 -> every result, banderas and flags_reg match reference model; no loss/reorder.
- Assert rst_n low with both stages full -> out_valid, c, banderas, flags_reg zero immediately; after release in_ready=1, next op normal.

Source files
------------

// File: rtl/suma_resta_seg_if.sv
// Handshake and data bundle of the pipelined add/subtract unit.
// The master side presents operations and consumes results; the slave side is the unit.
interface suma_resta_seg_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         set_flags;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic [3:0]   banderas;
  logic [3:0]   flags_reg;

  modport master (
    output in_valid, op, a, b, set_flags, out_ready,
    input  in_ready, out_valid, c, banderas, flags_reg
  );

  modport slave (
    input  in_valid, op, a, b, set_flags, out_ready,
    output in_ready, out_valid, c, banderas, flags_reg
  );
endinterface

// File: rtl/suma_resta_seg.sv
// Two-stage add/subtract unit with NZCV flags and an architectural flag register.
// S1 holds the operands, S2 the result; both stages use valid/ready flow control.
module suma_resta_seg #(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  suma_resta_seg_if.slave       bus
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADC  = 3'b001,
    OP_SUB  = 3'b010,
    OP_SBC  = 3'b011,
    OP_CMP  = 3'b100,
    OP_CMN  = 3'b101,
    OP_RSB  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  // Result and NZCV of x + y + cin; carry is the bit beyond N, V is signed overflow.
  function automatic logic [N+3:0] add_nzcv(input logic [N-1:0] x,
                                             input logic [N-1:0] y,
                                             input logic         cin);
    logic [N:0] sum;
    logic       v;
    sum = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
    v   = (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]);
    return {sum[N-1:0], sum[N-1], (sum[N-1:0] == {N{1'b0}}), sum[N], v};
  endfunction

  logic         s1_valid_r;
  op_e          s1_op_r;
  logic [N-1:0] s1_a_r;
  logic [N-1:0] s1_b_r;
  logic         s1_set_r;
  logic         s2_valid_r;
  logic [N-1:0] c_r;
  logic [3:0]   banderas_r;
  logic [3:0]   flags_r;

  logic         s2_pop_s;
  logic         s1_adv_s;
  logic         in_ready_s;
  logic         in_push_s;
  logic [N-1:0] x_s;
  logic [N-1:0] y_s;
  logic         cin_s;
  logic [N+3:0] res_s;
  logic [N-1:0] c_nxt_s;
  logic [3:0]   ban_nxt_s;
  logic         upd_s;

  assign s2_pop_s   = s2_valid_r && bus.out_ready;
  assign s1_adv_s   = s1_valid_r && (!s2_valid_r || s2_pop_s);
  assign in_ready_s = !s1_valid_r || s1_adv_s;
  assign in_push_s  = bus.in_valid && in_ready_s;

  // Adder operand selection, result/flag formation and flag-register update enable.
  always_comb begin
    x_s   = s1_a_r;
    y_s   = s1_b_r;
    cin_s = 1'b0;
    case (s1_op_r)
      OP_ADD, OP_CMN: begin x_s = s1_a_r; y_s = s1_b_r;  cin_s = 1'b0;       end
      OP_ADC:         begin x_s = s1_a_r; y_s = s1_b_r;  cin_s = flags_r[1]; end
      OP_SUB, OP_CMP: begin x_s = s1_a_r; y_s = ~s1_b_r; cin_s = 1'b1;       end
      OP_SBC:         begin x_s = s1_a_r; y_s = ~s1_b_r; cin_s = flags_r[1]; end
      OP_RSB:         begin x_s = s1_b_r; y_s = ~s1_a_r; cin_s = 1'b1;       end
      default:        begin x_s = s1_a_r; y_s = s1_b_r;  cin_s = 1'b0;       end
    endcase
    res_s = add_nzcv(x_s, y_s, cin_s);
    if (s1_op_r == OP_PASS) begin
      c_nxt_s   = s1_a_r;
      ban_nxt_s = 4'b0000;
      upd_s     = 1'b0;
    end else begin
      c_nxt_s   = res_s[N+3:4];
      ban_nxt_s = res_s[3:0];
      upd_s     = s1_set_r || (s1_op_r == OP_CMP) || (s1_op_r == OP_CMN);
    end
  end

  // Operand stage: fills on input handshake, drains when S2 can take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= OP_ADD;
      s1_a_r     <= {N{1'b0}};
      s1_b_r     <= {N{1'b0}};
      s1_set_r   <= 1'b0;
    end else if (in_push_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= op_e'(bus.op);
      s1_a_r     <= bus.a;
      s1_b_r     <= bus.b;
      s1_set_r   <= bus.set_flags;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Result stage and flag register; flags commit in program order as ops enter S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      c_r        <= {N{1'b0}};
      banderas_r <= 4'b0000;
      flags_r    <= 4'b0000;
    end else if (s1_adv_s) begin
      s2_valid_r <= 1'b1;
      c_r        <= c_nxt_s;
      banderas_r <= ban_nxt_s;
      if (upd_s) begin
        flags_r <= ban_nxt_s;
      end
    end else if (s2_pop_s) begin
      s2_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.c         = c_r;
  assign bus.banderas  = banderas_r;
  assign bus.flags_reg = flags_r;

endmodule

// File: tb/tb_suma_resta_seg.sv
// Bench for suma_resta_seg: three widths share one stimulus stream, each with its own
// arithmetic reference model and scoreboard, plus hand-computed 8-bit expectations.
module tb_suma_resta_seg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        set_flags;
  logic        out_ready;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : gw
    localparam int W = 8 << gi;

    suma_resta_seg_if #(.N(W)) sif ();
    assign sif.in_valid  = in_valid;
    assign sif.op        = op;
    assign sif.a         = a[W-1:0];
    assign sif.b         = b[W-1:0];
    assign sif.set_flags = set_flags;
    assign sif.out_ready = out_ready;

    suma_resta_seg #(.N(W)) dut (.clk(clk), .rst_n(rst_n), .bus(sif));

    logic [W+7:0] exp_q[$];
    logic [3:0]   mflags;
    logic [3:0]   last_flags;
    int           pending;

    // Exact integer arithmetic: C from unsigned magnitude, V from signed range.
    function automatic logic [W+3:0] ref_op(input logic [2:0] o, input logic [W-1:0] av,
                                             input logic [W-1:0] bv, input logic cf);
      longint m, ua, ub, sa, sb, us, ss, bw;
      logic cy;
      logic [W-1:0] r;
      m  = longint'(1) << W;
      ua = longint'(av);
      ub = longint'(bv);
      sa = av[W-1] ? ua - m : ua;
      sb = bv[W-1] ? ub - m : ub;
      bw = cf ? 0 : 1;
      case (o)
        3'd0, 3'd5: begin us = ua + ub;      ss = sa + sb;      cy = (us >= m); end
        3'd1:       begin us = ua + ub + (cf ? 1 : 0); ss = sa + sb + (cf ? 1 : 0); cy = (us >= m); end
        3'd2, 3'd4: begin us = ua - ub;      ss = sa - sb;      cy = (ua >= ub); end
        3'd3:       begin us = ua - ub - bw; ss = sa - sb - bw; cy = (ua >= ub + bw); end
        3'd6:       begin us = ub - ua;      ss = sb - sa;      cy = (ub >= ua); end
        default:    return {av, 4'b0000};
      endcase
      r = us[W-1:0];
      return {r, r[W-1], (r == {W{1'b0}}), cy, ((ss < -(m / 2)) || (ss >= m / 2))};
    endfunction

    initial begin
      logic [W+3:0] res;
      logic [W+7:0] head;
      mflags = 4'b0000;
      last_flags = 4'b0000;
      pending = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          exp_q.delete();
          mflags = 4'b0000;
          last_flags = 4'b0000;
          chk($sformatf("w%0d reset out_valid", W), sif.out_valid, 0);
          chk($sformatf("w%0d reset c", W), sif.c, 0);
          chk($sformatf("w%0d reset banderas", W), sif.banderas, 0);
          chk($sformatf("w%0d reset flags_reg", W), sif.flags_reg, 0);
        end else begin
          if (sif.out_valid) begin
            if (exp_q.size() == 0) begin
              chk($sformatf("w%0d spurious out_valid", W), sif.out_valid, 0);
            end else begin
              head = exp_q[0];
              chk($sformatf("w%0d c", W), sif.c, head[W+7:8]);
              chk($sformatf("w%0d banderas", W), sif.banderas, head[7:4]);
              chk($sformatf("w%0d flags_reg", W), sif.flags_reg, head[3:0]);
              if (out_ready) begin
                last_flags = head[3:0];
                void'(exp_q.pop_front());
              end
            end
          end else begin
            chk($sformatf("w%0d idle flags_reg", W), sif.flags_reg, last_flags);
          end
          if (in_valid && sif.in_ready) begin
            res = ref_op(op, a[W-1:0], b[W-1:0], mflags[1]);
            if ((set_flags || op == 3'd4 || op == 3'd5) && op != 3'd7) mflags = res[3:0];
            exp_q.push_back({res, mflags});
          end
        end
        pending = exp_q.size();
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic sf);
    int t;
    t = 0;
    in_valid = 1'b1; op = o; a = x; b = y; set_flags = sf;
    while (!gw[0].sif.in_ready && t < 100) begin
      @(posedge clk); #1;
      t = t + 1;
    end
    if (t >= 100) chk("send in_ready timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect8(input string nm, input logic [7:0] ec, input logic [3:0] eb,
                         input logic [3:0] ef);
    chk({nm, " out_valid"}, gw[0].sif.out_valid, 1);
    chk({nm, " c"}, gw[0].sif.c, ec);
    chk({nm, " banderas"}, gw[0].sif.banderas, eb);
    chk({nm, " flags_reg"}, gw[0].sif.flags_reg, ef);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_007F;
      3:       return 32'h0000_8000;
      4:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #500000;
    errors = errors + 1;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    in_valid = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; set_flags = 1'b0; out_ready = 1'b1;
    #3;
    chk("reset in_ready", gw[0].sif.in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("release in_ready", gw[0].sif.in_ready, 1);

    send(3'd0, 32'h7F, 32'h01, 1'b1);
    chk("latency out_valid", gw[0].sif.out_valid, 0);
    @(posedge clk); #1;
    expect8("add ovf", 8'h80, 4'b1001, 4'b1001);
    idle(2);

    send(3'd2, 32'h05, 32'h05, 1'b0);
    send(3'd4, 32'h00, 32'h01, 1'b0);
    expect8("sub zero", 8'h00, 4'b0110, 4'b1001);
    @(posedge clk); #1;
    expect8("cmp", 8'hFF, 4'b1000, 4'b1000);
    idle(2);

    send(3'd0, 32'hFF, 32'h01, 1'b1);
    send(3'd1, 32'h00, 32'h00, 1'b0);
    expect8("add carry", 8'h00, 4'b0110, 4'b0110);
    @(posedge clk); #1;
    expect8("adc", 8'h01, 4'b0000, 4'b0110);
    idle(2);

    send(3'd2, 32'h00, 32'h01, 1'b1);
    send(3'd3, 32'h00, 32'h00, 1'b0);
    expect8("sub borrow", 8'hFF, 4'b1000, 4'b1000);
    @(posedge clk); #1;
    expect8("sbc", 8'hFF, 4'b1000, 4'b1000);
    idle(2);

    send(3'd6, 32'h03, 32'h10, 1'b1);
    send(3'd7, 32'h5A, 32'h11, 1'b1);
    expect8("rsb", 8'h0D, 4'b0010, 4'b0010);
    @(posedge clk); #1;
    expect8("pass", 8'h5A, 4'b0000, 4'b0010);
    idle(2);

    out_ready = 1'b0;
    send(3'd0, 32'h10, 32'h20, 1'b0);
    send(3'd0, 32'h01, 32'h01, 1'b0);
    in_valid = 1'b1; op = 3'd0; a = 32'h03; b = 32'h04; set_flags = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp in_ready", gw[0].sif.in_ready, 0);
      expect8("bp hold", 8'h30, 4'b0000, 4'b0010);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 chk("bp push+pop in_ready", gw[0].sif.in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect8("bp second", 8'h02, 4'b0000, 4'b0010);
    @(posedge clk); #1;
    expect8("bp third", 8'h07, 4'b0000, 4'b0010);
    idle(2);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      acc = in_valid && gw[0].sif.in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        op = 3'($urandom_range(0, 7));
        a = pick();
        b = pick();
        set_flags = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("w8 drained", gw[0].pending, 0);
    chk("w16 drained", gw[1].pending, 0);
    chk("w32 drained", gw[2].pending, 0);

    out_ready = 1'b0;
    send(3'd0, 32'h7F, 32'h01, 1'b1);
    send(3'd0, 32'h01, 32'h02, 1'b1);
    chk("full before reset", gw[0].sif.flags_reg, 4'b1001);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", gw[0].sif.out_valid, 0);
    chk("async rst c", gw[0].sif.c, 0);
    chk("async rst banderas", gw[0].sif.banderas, 0);
    chk("async rst flags_reg", gw[0].sif.flags_reg, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post rst in_ready", gw[0].sif.in_ready, 1);
    out_ready = 1'b1;
    send(3'd0, 32'h02, 32'h03, 1'b1);
    @(posedge clk); #1;
    expect8("post rst add", 8'h05, 4'b0000, 4'b0000);
    idle(4);
    chk("w8 final drained", gw[0].pending, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
